comparator_result_serializer: RTL and testbench
===============================================

Name: comparator_result_serializer

Overview:
- Downstream stage of the 32-lane, 2-bit-per-lane comparator array.
- Captures the array's 64-bit D_OUT vector on a strobe and counts the lanes holding a non-zero result.
- Streams the captured vector out as OUT_W-bit beats over a valid/ready handshake to the host-side readout path.
- Flags captures lost while a previous vector is still draining.

Parameters:
- DATA_W, 64: width of the captured vector; must equal LANES*LANE_W.
- LANE_W, 2: bits per comparator lane.
- OUT_W, 16: beat width; DATA_W must be an integer multiple of OUT_W.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTL  in  1  asynchronous active-low reset.
- D_IN  in  DATA_W  comparator array output vector.
- CAP_EN  in  1  capture request for D_IN.
- CAP_READY  out  1  capture accepted this cycle if CAP_EN=1.
- ABORT  in  1  synchronous drop of the vector in flight.
- O_DATA  out  OUT_W  current beat.
- O_VALID  out  1  beat valid.
- O_READY  in  1  consumer accepts beat.
- O_LAST  out  1  final beat of vector.
- HIT_CNT  out  $clog2(LANES+1)  non-zero lane count of the captured vector.
- OVF  out  1  sticky lost-capture flag.
- CLR_OVF  in  1  clears OVF.
- BUSY  out  1  high while in SEND.

Behaviour:
- Reset (RSTL=0, asynchronous):
  - State=IDLE.
  - Shift register, beat counter, O_DATA, HIT_CNT: all 0.
  - O_VALID=0, O_LAST=0, OVF=0, BUSY=0.
  - Reset mid-transfer discards the vector; no partial beat is ever seen after release.
- Derived constants: LANES=DATA_W/LANE_W; BEATS=DATA_W/OUT_W (4 at defaults).
- CAP_READY (combinational) = (state==IDLE) | (state==SEND & O_LAST & O_READY).
- State IDLE:
  - O_VALID=0.
  - CAP_EN=1 → latch D_IN into the shift register, HIT_CNT ← number of lanes with value≠0, beat counter ← 0, go to SEND.
  - O_VALID rises the cycle after capture (latency 1).
- State SEND:
  - O_VALID=1 and BUSY=1.
  - O_DATA = shift register [OUT_W-1:0]; lowest lane is sent first.
  - O_LAST=1 when beat counter==BEATS-1.
  - Handshake: a beat transfers when O_VALID & O_READY; the register then shifts right by OUT_W and the counter increments.
  - O_DATA, O_LAST and HIT_CNT hold stable while O_VALID & !O_READY.
  - Last beat accepted, CAP_EN=0 → IDLE.
  - Last beat accepted, CAP_EN=1 → recapture and stay in SEND. No bubble; the new vector's first beat is valid the next cycle.
- Lost capture: CAP_EN=1 while CAP_READY=0 → capture dropped, OVF←1 (sticky). Same-cycle CLR_OVF and new loss: set wins.
- HIT_CNT holds its value until the next capture, including through IDLE.
- ABORT=1:
  - In SEND: state←IDLE next cycle, O_VALID←0; a beat accepted in the same cycle still counts. OVF and HIT_CNT are unchanged.
  - In IDLE: ABORT has priority over CAP_EN, which is not accepted; CAP_READY is gated to 0 during ABORT.
- Only counting wraps, and the counter never exceeds BEATS-1.

Decomposition:
- Shared package comparator_pkg:
  - state enum {IDLE, SEND};
  - LANES, BEATS, CNT_W localparams;
  - lane width constant LANE_W=2, shared with the comparator array.
- Sub-module lane_nz_popcount: combinational count of non-zero LANE_W-bit lanes in a DATA_W vector. It is reusable by other array readouts.

Test Plan:
- Basic capture: D_IN=64'h0000_0000_0000_0003, CAP_EN pulse, O_READY=1.
  - Expect 4 beats: 0003, 0000, 0000, 0000.
  - O_LAST on beat 4; HIT_CNT=1; back to IDLE.
- Backpressure: D_IN=64'hFFFF_AAAA_5555_0000, O_READY toggling 1,0,0,1.
  - Expect order 0000, 5555, AAAA, FFFF.
  - O_DATA stable during stalls; HIT_CNT=24.
- Back-to-back: CAP_EN held on the last-beat accept cycle with a new D_IN=64'h1.
  - Expect CAP_READY=1 and no idle cycle.
  - Next beat is 0001; OVF stays 0.
- Overflow: CAP_EN during beat 2.
  - Expect CAP_READY=0, OVF=1, in-flight data unchanged.
  - Then CLR_OVF alone → OVF=0.
  - Then CLR_OVF together with a new loss → OVF=1.
- Abort and reset:
  - ABORT on beat 2 → O_VALID=0 next cycle; a new capture then sends from beat 0.
  - RSTL low mid-SEND → all outputs 0 immediately.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared constants and types for the comparator array readout path.
// LANE_W is shared with the comparator array; LANES/BEATS/CNT_W/HIT_W
// are derived for the default 64-bit vector streamed as 16-bit beats.
package comparator_pkg;

    localparam int unsigned LANE_W     = 2;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_OUT_W  = 16;
    localparam int unsigned LANES      = DEF_DATA_W / LANE_W;
    localparam int unsigned BEATS      = DEF_DATA_W / DEF_OUT_W;
    localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned HIT_W      = $clog2(LANES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/comparator_result_serializer_if.sv
// Capture / beat-stream / status bundle of the comparator result serializer.
// master: host side (drives capture request, abort, beat ready, ovf clear).
// slave : serializer side (drives capture ready, beats, hit count, status).
interface comparator_result_serializer_if #(
    parameter int unsigned DATA_W = comparator_pkg::DEF_DATA_W,
    parameter int unsigned OUT_W  = comparator_pkg::DEF_OUT_W,
    parameter int unsigned HIT_W  = comparator_pkg::HIT_W
);

    logic [DATA_W-1:0] D_IN;
    logic              CAP_EN;
    logic              CAP_READY;
    logic              ABORT;
    logic [OUT_W-1:0]  O_DATA;
    logic              O_VALID;
    logic              O_READY;
    logic              O_LAST;
    logic [HIT_W-1:0]  HIT_CNT;
    logic              OVF;
    logic              CLR_OVF;
    logic              BUSY;

    modport master (
        output D_IN, CAP_EN, ABORT, O_READY, CLR_OVF,
        input  CAP_READY, O_DATA, O_VALID, O_LAST, HIT_CNT, OVF, BUSY
    );

    modport slave (
        input  D_IN, CAP_EN, ABORT, O_READY, CLR_OVF,
        output CAP_READY, O_DATA, O_VALID, O_LAST, HIT_CNT, OVF, BUSY
    );

endinterface

// File: rtl/lane_nz_popcount.sv
// Combinational count of non-zero LANE_W-bit lanes in a DATA_W vector.
// vec_i    : packed lane vector, lane 0 in the LSBs
// nz_cnt_o : number of lanes whose value is not zero
module lane_nz_popcount #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned CNT_W  = 6
) (
    input  logic [DATA_W-1:0] vec_i,
    output logic [CNT_W-1:0]  nz_cnt_o
);

    localparam int unsigned N_LANES = DATA_W / LANE_W;

    always_comb begin
        nz_cnt_o = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (|vec_i[i*LANE_W +: LANE_W]) begin
                nz_cnt_o = nz_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/comparator_result_serializer.sv
// Captures the comparator array vector, counts non-zero lanes and streams the
// vector out lowest lane first as OUT_W-bit beats over valid/ready.
// CLK  : clock, rising edge
// RSTL : asynchronous active-low reset
// bus  : capture request/ready, abort, beat stream, hit count, overflow, busy
module comparator_result_serializer #(
    parameter int unsigned DATA_W = comparator_pkg::DEF_DATA_W,
    parameter int unsigned LANE_W = comparator_pkg::LANE_W,
    parameter int unsigned OUT_W  = comparator_pkg::DEF_OUT_W
) (
    input  logic                           CLK,
    input  logic                           RSTL,
    comparator_result_serializer_if.slave  bus
);

    import comparator_pkg::*;

    localparam int unsigned N_LANES = DATA_W / LANE_W;
    localparam int unsigned N_BEATS = DATA_W / OUT_W;
    localparam int unsigned BCNT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned HCNT_W  = $clog2(N_LANES + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(N_BEATS - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic [HCNT_W-1:0]   hit_q, hit_d;
    logic                ovf_q, ovf_d;
    logic [HCNT_W-1:0]   hit_c;
    logic                last_c;
    logic                fire_c;
    logic                cap_ready_c;
    logic                load_c;

    lane_nz_popcount #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .CNT_W  (HCNT_W)
    ) u_popcount (
        .vec_i    (bus.D_IN),
        .nz_cnt_o (hit_c)
    );

    // Capture is possible when idle or when the last beat leaves this cycle;
    // ABORT blocks any capture in the same cycle.
    assign last_c      = (state_q == SEND) && (cnt_q == LAST_BEAT);
    assign fire_c      = (state_q == SEND) && bus.O_READY;
    assign cap_ready_c = !bus.ABORT && ((state_q == IDLE) || (last_c && bus.O_READY));
    assign load_c      = bus.CAP_EN && cap_ready_c;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        ovf_d   = ovf_q;

        // Set after clear so a same-cycle loss wins.
        if (bus.CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (bus.CAP_EN && !cap_ready_c) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_c) begin
                    sr_d    = bus.D_IN;
                    hit_d   = hit_c;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fire_c) begin
                    sr_d = sr_q >> OUT_W;
                    if (last_c) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + BCNT_W'(1);
                    end
                end
                // Back-to-back recapture on the final accept: no bubble.
                if (load_c) begin
                    sr_d    = bus.D_IN;
                    hit_d   = hit_c;
                    cnt_d   = '0;
                    state_d = SEND;
                end
                if (bus.ABORT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            hit_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode registered state directly.
    assign bus.CAP_READY = cap_ready_c;
    assign bus.O_VALID   = (state_q == SEND);
    assign bus.BUSY      = (state_q == SEND);
    assign bus.O_LAST    = last_c;
    assign bus.O_DATA    = sr_q[OUT_W-1:0];
    assign bus.HIT_CNT   = hit_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_comparator_result_serializer.sv
// Directed testbench for comparator_result_serializer.
module tb_comparator_result_serializer;

    logic CLK = 1'b0;
    logic RSTL;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    comparator_result_serializer_if #(.DATA_W(64), .OUT_W(16), .HIT_W(6)) bus ();

    comparator_result_serializer #(.DATA_W(64), .LANE_W(2), .OUT_W(16)) dut (
        .CLK  (CLK),
        .RSTL (RSTL),
        .bus  (bus.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        RSTL = 1'b0;
        bus.D_IN = '0; bus.CAP_EN = 1'b0; bus.ABORT = 1'b0;
        bus.O_READY = 1'b1; bus.CLR_OVF = 1'b0;
        @(negedge CLK); #1;
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.O_VALID); end
        checks++; if (bus.O_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.O_LAST); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.OVF); end
        checks++; if (bus.HIT_CNT !== 6'd0) begin errors++; $display("FAIL reset_hit: got %0d expected 0", bus.HIT_CNT); end
        checks++; if (bus.O_DATA !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.O_DATA); end
        checks++; if (bus.CAP_READY !== 1'b1) begin errors++; $display("FAIL reset_cap_ready: got %b expected 1", bus.CAP_READY); end
        @(negedge CLK);
        RSTL = 1'b1;
    endtask

    task automatic test_basic;
        logic [15:0] exp_b [4];
        exp_b[0] = 16'h0003; exp_b[1] = 16'h0000; exp_b[2] = 16'h0000; exp_b[3] = 16'h0000;
        @(negedge CLK);
        bus.D_IN = 64'h0000_0000_0000_0003; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        #1;
        checks++; if (bus.CAP_READY !== 1'b1) begin errors++; $display("FAIL basic_cap_ready: got %b expected 1", bus.CAP_READY); end
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.HIT_CNT !== 6'd1) begin errors++; $display("FAIL basic_hit: got %0d expected 1", bus.HIT_CNT); end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge CLK);
            checks++; if (bus.O_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d: got %b expected 1", b, bus.O_VALID); end
            checks++; if (bus.O_DATA !== exp_b[b]) begin errors++; $display("FAIL basic_data beat %0d: got %h expected %h", b, bus.O_DATA, exp_b[b]); end
            checks++; if (bus.O_LAST !== (b == 3)) begin errors++; $display("FAIL basic_last beat %0d: got %b expected %b", b, bus.O_LAST, (b == 3)); end
        end
        @(negedge CLK);
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b expected 0", bus.O_VALID); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.HIT_CNT !== 6'd1) begin errors++; $display("FAIL basic_hit_hold: got %0d expected 1", bus.HIT_CNT); end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_b [4];
        logic        pat [4];
        int          idx;
        int          k;
        exp_b[0] = 16'h0000; exp_b[1] = 16'h5555; exp_b[2] = 16'hAAAA; exp_b[3] = 16'hFFFF;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        @(negedge CLK);
        bus.D_IN = 64'hFFFF_AAAA_5555_0000; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.HIT_CNT !== 6'd24) begin errors++; $display("FAIL bp_hit: got %0d expected 24", bus.HIT_CNT); end
        idx = 0;
        k = 0;
        while (idx < 4 && k < 20) begin
            bus.O_READY = pat[k % 4];
            checks++; if (bus.O_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d: got %b expected 1", k, bus.O_VALID); end
            checks++; if (bus.O_DATA !== exp_b[idx]) begin errors++; $display("FAIL bp_data cycle %0d: got %h expected %h", k, bus.O_DATA, exp_b[idx]); end
            checks++; if (bus.O_LAST !== (idx == 3)) begin errors++; $display("FAIL bp_last cycle %0d: got %b expected %b", k, bus.O_LAST, (idx == 3)); end
            if (pat[k % 4]) idx++;
            k++;
            @(negedge CLK);
        end
        bus.O_READY = 1'b1;
        checks++; if (idx !== 4) begin errors++; $display("FAIL bp_timeout: got %0d beats expected 4", idx); end
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", bus.O_VALID); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_b [4];
        exp_b[0] = 16'h0009; exp_b[1] = 16'h0002; exp_b[2] = 16'h0003; exp_b[3] = 16'h0004;
        @(negedge CLK);
        bus.D_IN = 64'h0004_0003_0002_0009; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.HIT_CNT !== 6'd5) begin errors++; $display("FAIL b2b_hit_a: got %0d expected 5", bus.HIT_CNT); end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge CLK);
            checks++; if (bus.O_DATA !== exp_b[b]) begin errors++; $display("FAIL b2b_data beat %0d: got %h expected %h", b, bus.O_DATA, exp_b[b]); end
        end
        bus.D_IN = 64'h0000_0000_0000_0001; bus.CAP_EN = 1'b1;
        #1;
        checks++; if (bus.O_LAST !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b expected 1", bus.O_LAST); end
        checks++; if (bus.CAP_READY !== 1'b1) begin errors++; $display("FAIL b2b_cap_ready: got %b expected 1", bus.CAP_READY); end
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.O_VALID !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got %b expected 1", bus.O_VALID); end
        checks++; if (bus.O_DATA !== 16'h0001) begin errors++; $display("FAIL b2b_first: got %h expected 0001", bus.O_DATA); end
        checks++; if (bus.O_LAST !== 1'b0) begin errors++; $display("FAIL b2b_first_last: got %b expected 0", bus.O_LAST); end
        checks++; if (bus.HIT_CNT !== 6'd1) begin errors++; $display("FAIL b2b_hit_b: got %0d expected 1", bus.HIT_CNT); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", bus.OVF); end
        repeat (4) @(negedge CLK);
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.O_VALID); end
    endtask

    task automatic test_overflow;
        @(negedge CLK);
        bus.D_IN = 64'h4444_3333_2222_1111; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.HIT_CNT !== 6'd16) begin errors++; $display("FAIL ovf_hit: got %0d expected 16", bus.HIT_CNT); end
        @(negedge CLK);
        bus.D_IN = 64'hDEAD_BEEF_0000_0001; bus.CAP_EN = 1'b1;
        #1;
        checks++; if (bus.CAP_READY !== 1'b0) begin errors++; $display("FAIL ovf_cap_ready: got %b expected 0", bus.CAP_READY); end
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.OVF); end
        checks++; if (bus.O_DATA !== 16'h3333) begin errors++; $display("FAIL ovf_inflight: got %h expected 3333", bus.O_DATA); end
        checks++; if (bus.HIT_CNT !== 6'd16) begin errors++; $display("FAIL ovf_hit_keep: got %0d expected 16", bus.HIT_CNT); end
        @(negedge CLK);
        checks++; if (bus.O_DATA !== 16'h4444) begin errors++; $display("FAIL ovf_last_data: got %h expected 4444", bus.O_DATA); end
        @(negedge CLK);
        bus.CLR_OVF = 1'b1;
        @(negedge CLK);
        bus.CLR_OVF = 1'b0;
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.OVF); end
        bus.D_IN = 64'h4444_3333_2222_1111; bus.CAP_EN = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        @(negedge CLK);
        bus.CAP_EN = 1'b1; bus.CLR_OVF = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0; bus.CLR_OVF = 1'b0;
        checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.OVF); end
        repeat (2) @(negedge CLK);
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b expected 0", bus.O_VALID); end
        bus.CLR_OVF = 1'b1;
        @(negedge CLK);
        bus.CLR_OVF = 1'b0;
    endtask

    task automatic test_abort;
        @(negedge CLK);
        bus.D_IN = 64'h4444_3333_2222_1111; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        @(negedge CLK);
        bus.ABORT = 1'b1;
        checks++; if (bus.O_DATA !== 16'h2222) begin errors++; $display("FAIL abort_beat2: got %h expected 2222", bus.O_DATA); end
        @(negedge CLK);
        bus.ABORT = 1'b0;
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.O_VALID); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.HIT_CNT !== 6'd16) begin errors++; $display("FAIL abort_hit: got %0d expected 16", bus.HIT_CNT); end
        checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b expected 0", bus.OVF); end
        bus.ABORT = 1'b1; bus.CAP_EN = 1'b1; bus.D_IN = 64'h0000_0000_0000_00AB;
        #1;
        checks++; if (bus.CAP_READY !== 1'b0) begin errors++; $display("FAIL abort_idle_gate: got %b expected 0", bus.CAP_READY); end
        @(negedge CLK);
        bus.ABORT = 1'b0; bus.CAP_EN = 1'b0; bus.CLR_OVF = 1'b1;
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL abort_idle_nocap: got %b expected 0", bus.O_VALID); end
        @(negedge CLK);
        bus.CLR_OVF = 1'b0; bus.CAP_EN = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        checks++; if (bus.O_DATA !== 16'h00AB) begin errors++; $display("FAIL abort_restart_data: got %h expected 00ab", bus.O_DATA); end
        checks++; if (bus.O_LAST !== 1'b0) begin errors++; $display("FAIL abort_restart_last: got %b expected 0", bus.O_LAST); end
        checks++; if (bus.HIT_CNT !== 6'd4) begin errors++; $display("FAIL abort_restart_hit: got %0d expected 4", bus.HIT_CNT); end
        repeat (4) @(negedge CLK);
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL abort_restart_end: got %b expected 0", bus.O_VALID); end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        bus.D_IN = 64'h4444_3333_2222_1111; bus.CAP_EN = 1'b1; bus.O_READY = 1'b1;
        @(negedge CLK);
        bus.CAP_EN = 1'b0;
        @(negedge CLK);
        RSTL = 1'b0;
        #1;
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.O_VALID); end
        checks++; if (bus.O_DATA !== 16'h0000) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", bus.O_DATA); end
        checks++; if (bus.HIT_CNT !== 6'd0) begin errors++; $display("FAIL rstmid_hit: got %0d expected 0", bus.HIT_CNT); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.O_LAST !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", bus.O_LAST); end
        @(negedge CLK);
        RSTL = 1'b1;
        @(negedge CLK);
        checks++; if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", bus.O_VALID); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
